fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 24, sample width in bits.
REQ-002 Parameter FIR_DEPTH, 128, tap count, power of two, >= 4; AW = log2(FIR_DEPTH).
REQ-003 Parameter MEM_LATENCY, 2, read latency in cycles from address to MAC operands, 1..4.
REQ-004 i_clk  in  1  single clock, rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_en  in  1  global enable; low freezes all state.
REQ-007 i_din_valid  in  1  input sample valid.
REQ-008 o_din_ready  out  1  sequencer accepts a sample.
REQ-009 iv_din  in  DATA_WIDTH  input sample.
REQ-010 o_smp_we, ov_smp_waddr[AW], ov_smp_wdata[DATA_WIDTH]  out  sample-memory write port.
REQ-011 ov_smp_raddr[AW], ov_coef_raddr[AW]  out  sample and coefficient read addresses.
REQ-012 o_mac_clr, o_mac_en  out  1 each  external MAC load-first-product and accumulate strobes.
REQ-013 o_dout_valid  out  1, i_dout_ready  in  1  result handshake; accumulator is final while o_dout_valid is high.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 States: CLEAR, IDLE, RUN, DRAIN, DONE; all registered.
REQ-016 IDLE: o_din_ready=1; on i_din_valid & o_din_ready (cycle T): o_smp_we=1, waddr=wr_ptr, wdata=iv_din; base=wr_ptr; wr_ptr increments mod FIR_DEPTH; tap k=0; next state RUN.
REQ-017 RUN: cycles T+1..T+FIR_DEPTH, k=0..FIR_DEPTH-1; ov_smp_raddr=(base-k) mod FIR_DEPTH; ov_coef_raddr=k; after k=FIR_DEPTH-1, go DRAIN.
REQ-018 o_mac_en asserted exactly MEM_LATENCY cycles after each RUN address cycle; o_mac_clr asserted only with the k=0 o_mac_en.
REQ-019 DRAIN lasts MEM_LATENCY cycles, then DONE; o_dout_valid rises at T+FIR_DEPTH+MEM_LATENCY+1.
REQ-020 DONE: o_dout_valid held high until i_dout_ready sampled high; next state IDLE; o_din_ready is low outside IDLE.
REQ-021 CLEAR: FIR_DEPTH cycles writing 0 to addresses 0..FIR_DEPTH-1 in order, o_mac_en=0, then IDLE with wr_ptr=0.
REQ-022 i_en low: state, wr_ptr, k, delay pipeline frozen; o_smp_we, o_mac_en, o_mac_clr and o_din_ready forced 0; o_dout_valid holds; completion delayed exactly by the low cycles.
REQ-023 Outside IDLE/CLEAR writes, o_smp_we=0 and ov_smp_wdata=0; read addresses hold last value outside RUN.
REQ-024 wr_ptr wraps FIR_DEPTH-1 -> 0 with no gap; base-k subtraction wraps modulo FIR_DEPTH.

Reset
REQ-025 While i_rst high: all outputs 0 (except o_busy, which follows the entry state), wr_ptr=0, k=0, delay pipeline cleared; a run in progress is aborted without o_dout_valid.
REQ-026 After i_rst falls, entry state is CLEAR (macro defined) or IDLE (macro undefined).

Configuration
REQ-027 Macro FIR_CLEAR_ON_RESET_EN: defined -> CLEAR pass per REQ-021 after every reset; undefined -> CLEAR state and its logic are not compiled, reset enters IDLE, and sample memory contents are left untouched.

Structure
REQ-028 Shared package fir_ctrl_pkg: state enumeration, address-width function, MEM_LATENCY bounds constants.
REQ-029 One sub-module fir_ctrl_delay_line: MEM_LATENCY-deep enable-gated shift register carrying o_mac_en and o_mac_clr.

Verification (FIR_DEPTH=8, MEM_LATENCY=2)
REQ-030 Reset release, macro defined -> 8 cycles o_smp_we=1, waddr 0..7, wdata 0, o_din_ready=0, o_busy=1; then IDLE, o_din_ready=1.
REQ-031 One sample 0x000123 at cycle T -> waddr 0 at T; smp_raddr 0,7,6,5,4,3,2,1 and coef_raddr 0..7 at T+1..T+8; mac_clr only at T+3; mac_en at T+3..T+10; o_dout_valid at T+11.
REQ-032 i_dout_ready low 5 cycles in DONE -> o_dout_valid held, o_din_ready=0; after ready, IDLE next cycle.
REQ-033 Nine back-to-back samples -> ninth writes address 0, its smp_raddr sequence is 0,7,...,1.
REQ-034 i_en low 3 cycles at k=4 -> addresses and strobes freeze, o_dout_valid at T+14.
REQ-035 i_rst pulse at k=5 -> outputs zero immediately, no o_dout_valid, CLEAR restarts, next sample written at address 0.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_pkg
// Description : Shared types and helpers for the FIR MAC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fir_state_t;

    localparam int c_mem_latency_min = 1;
    localparam int c_mem_latency_max = 4;

    function automatic int fir_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_delay_line
// Description : Enable-gated shift register aligning MAC strobes with the
//               memory read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl_delay_line
    import fir_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_mac_en,
    input  logic i_mac_clr,
    output logic o_mac_en,
    output logic o_mac_clr
);

    localparam int c_depth = (DEPTH < c_mem_latency_min) ? c_mem_latency_min :
                             (DEPTH > c_mem_latency_max) ? c_mem_latency_max : DEPTH;

    logic [c_depth-1:0] r_en_sr;
    logic [c_depth-1:0] r_clr_sr;

    generate
        if (c_depth == 1) begin : g_single
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_en_sr  <= '0;
                    r_clr_sr <= '0;
                end else if (i_en) begin
                    r_en_sr  <= i_mac_en;
                    r_clr_sr <= i_mac_clr;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_en_sr  <= '0;
                    r_clr_sr <= '0;
                end else if (i_en) begin
                    r_en_sr  <= {r_en_sr[c_depth-2:0], i_mac_en};
                    r_clr_sr <= {r_clr_sr[c_depth-2:0], i_mac_clr};
                end
            end
        end
    endgenerate

    // Strobes are suppressed while frozen; the pipeline contents survive.
    assign o_mac_en  = r_en_sr[c_depth-1] & i_en;
    assign o_mac_clr = r_clr_sr[c_depth-1] & i_en;

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Sample-memory write / tap address sequencer for an external
//               FIR MAC. Macro FIR_CLEAR_ON_RESET_EN adds a memory-clear pass.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH  = 24,
    parameter int  FIR_DEPTH   = 128,
    parameter int  MEM_LATENCY = 2,
    localparam int AW          = fir_addr_width(FIR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_din_valid,
    output logic                  o_din_ready,
    input  logic [DATA_WIDTH-1:0] iv_din,
    output logic                  o_smp_we,
    output logic [AW-1:0]         ov_smp_waddr,
    output logic [DATA_WIDTH-1:0] ov_smp_wdata,
    output logic [AW-1:0]         ov_smp_raddr,
    output logic [AW-1:0]         ov_coef_raddr,
    output logic                  o_mac_clr,
    output logic                  o_mac_en,
    output logic                  o_dout_valid,
    input  logic                  i_dout_ready,
    output logic                  o_busy
);

    localparam logic [AW-1:0] c_last_tap   = AW'(FIR_DEPTH - 1);
    localparam logic [AW-1:0] c_last_drain = AW'(MEM_LATENCY - 1);
`ifdef FIR_CLEAR_ON_RESET_EN
    localparam fir_state_t c_entry_state = ST_CLEAR;
`else
    localparam fir_state_t c_entry_state = ST_IDLE;
`endif

    fir_state_t    r_state;
    fir_state_t    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_tap;
    logic [AW-1:0] r_smp_raddr;
    logic [AW-1:0] r_coef_raddr;
    logic          w_go;
    logic          w_accept;
    logic          w_clear_we;
    logic          w_pipe_en;
    logic          w_pipe_clr;

    // Combinational strobes are masked by reset so every output is quiet in reset.
    assign w_go     = i_en & ~i_rst;
    assign w_accept = (r_state == ST_IDLE) & i_din_valid & w_go;
`ifdef FIR_CLEAR_ON_RESET_EN
    assign w_clear_we = (r_state == ST_CLEAR) & w_go;
`else
    assign w_clear_we = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef FIR_CLEAR_ON_RESET_EN
            ST_CLEAR: if (r_wr_ptr == c_last_tap)   w_state_nxt = ST_IDLE;
`endif
            ST_IDLE:  if (i_din_valid)              w_state_nxt = ST_RUN;
            ST_RUN:   if (r_tap == c_last_tap)      w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_tap == c_last_drain)    w_state_nxt = ST_DONE;
            ST_DONE:  if (i_dout_ready)             w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= c_entry_state;
            r_wr_ptr     <= '0;
            r_tap        <= '0;
            r_smp_raddr  <= '0;
            r_coef_raddr <= '0;
        end else if (i_en) begin
            r_state <= w_state_nxt;
            case (r_state)
`ifdef FIR_CLEAR_ON_RESET_EN
                ST_CLEAR: r_wr_ptr <= r_wr_ptr + 1'b1;
`endif
                ST_IDLE: begin
                    if (i_din_valid) begin
                        r_wr_ptr     <= r_wr_ptr + 1'b1;
                        r_smp_raddr  <= r_wr_ptr;
                        r_coef_raddr <= '0;
                        r_tap        <= '0;
                    end
                end
                ST_RUN: begin
                    // Addresses are presented one cycle ahead; hold them after the last tap.
                    if (r_tap == c_last_tap) begin
                        r_tap <= '0;
                    end else begin
                        r_tap        <= r_tap + 1'b1;
                        r_smp_raddr  <= r_smp_raddr - 1'b1;
                        r_coef_raddr <= r_coef_raddr + 1'b1;
                    end
                end
                ST_DRAIN: r_tap <= r_tap + 1'b1;
                default: ;
            endcase
        end
    end

    assign w_pipe_en  = (r_state == ST_RUN);
    assign w_pipe_clr = (r_state == ST_RUN) & (r_tap == '0);

    fir_ctrl_delay_line #(
        .DEPTH (MEM_LATENCY)
    ) u_delay_line (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_mac_en  (w_pipe_en),
        .i_mac_clr (w_pipe_clr),
        .o_mac_en  (o_mac_en),
        .o_mac_clr (o_mac_clr)
    );

    assign o_din_ready   = (r_state == ST_IDLE) & w_go;
    assign o_smp_we      = w_accept | w_clear_we;
    assign ov_smp_waddr  = r_wr_ptr;
    assign ov_smp_wdata  = w_accept ? iv_din : '0;
    assign ov_smp_raddr  = r_smp_raddr;
    assign ov_coef_raddr = r_coef_raddr;
    assign o_dout_valid  = (r_state == ST_DONE);
    assign o_busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer (depth 8, latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int D  = 8;
    localparam int ML = 2;
    localparam int DW = 24;
`ifdef FIR_CLEAR_ON_RESET_EN
    localparam int c_clear_cycles = D;
`else
    localparam int c_clear_cycles = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en = 1'b0;
    logic          i_din_valid = 1'b0;
    logic          o_din_ready;
    logic [DW-1:0] iv_din = '0;
    logic          o_smp_we;
    logic [2:0]    ov_smp_waddr;
    logic [DW-1:0] ov_smp_wdata;
    logic [2:0]    ov_smp_raddr;
    logic [2:0]    ov_coef_raddr;
    logic          o_mac_clr;
    logic          o_mac_en;
    logic          o_dout_valid;
    logic          i_dout_ready = 1'b0;
    logic          o_busy;

    fir_mac_sequencer #(
        .DATA_WIDTH  (DW),
        .FIR_DEPTH   (D),
        .MEM_LATENCY (ML)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_din_valid   (i_din_valid),
        .o_din_ready   (o_din_ready),
        .iv_din        (iv_din),
        .o_smp_we      (o_smp_we),
        .ov_smp_waddr  (ov_smp_waddr),
        .ov_smp_wdata  (ov_smp_wdata),
        .ov_smp_raddr  (ov_smp_raddr),
        .ov_coef_raddr (ov_coef_raddr),
        .o_mac_clr     (o_mac_clr),
        .o_mac_en      (o_mac_en),
        .o_dout_valid  (o_dout_valid),
        .i_dout_ready  (i_dout_ready),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts enabled cycles since acceptance (phase p = 1 is the k=0 address cycle).
    int m_clear_left, m_wr, m_base, m_sr, m_cr, m_p;
    bit m_run;
    int g_cyc, g_acc_cyc, g_dv_first;

    task automatic model_reset();
        m_clear_left = c_clear_cycles;
        m_wr = 0; m_sr = 0; m_cr = 0; m_p = 0; m_run = 1'b0;
    endtask

    task automatic model_step();
        bit clr_ph, idle, acc;
        clr_ph = (m_clear_left > 0);
        idle   = !clr_ph && !m_run;
        acc    = i_en && idle && i_din_valid;
        if (m_run && m_p >= 1 && m_p <= D) begin
            m_sr = (m_base - (m_p - 1) + D) % D;
            m_cr = m_p - 1;
        end
        chk("din_ready",  o_din_ready,  i_en && idle);
        chk("busy",       o_busy,       !idle);
        chk("smp_we",     o_smp_we,     i_en && (clr_ph || acc));
        if (i_en && (clr_ph || acc)) chk("smp_waddr", ov_smp_waddr, m_wr);
        chk("smp_wdata",  ov_smp_wdata, acc ? iv_din : 0);
        chk("smp_raddr",  ov_smp_raddr, m_sr);
        chk("coef_raddr", ov_coef_raddr, m_cr);
        chk("mac_en",     o_mac_en,     i_en && m_run && m_p >= 1 + ML && m_p <= D + ML);
        chk("mac_clr",    o_mac_clr,    i_en && m_run && m_p == 1 + ML);
        chk("dout_valid", o_dout_valid, m_run && m_p > D + ML);
        if (o_dout_valid && g_dv_first < 0) g_dv_first = g_cyc;
        if (acc) g_acc_cyc = g_cyc;
        if (i_en) begin
            if (clr_ph) begin
                m_wr = (m_wr + 1) % D;
                m_clear_left--;
            end else if (idle) begin
                if (i_din_valid) begin
                    m_base = m_wr;
                    m_wr   = (m_wr + 1) % D;
                    m_run  = 1'b1;
                    m_p    = 1;
                end
            end else if (m_p > D + ML) begin
                if (i_dout_ready) m_run = 1'b0;
            end else begin
                m_p++;
            end
        end
        g_cyc++;
    endtask

    task automatic set_inputs(input bit en, input bit valid, input logic [DW-1:0] din, input bit dready);
        i_en = en; i_din_valid = valid; iv_din = din; i_dout_ready = dready;
    endtask

    task automatic drive_cycle(input bit en, input bit valid, input logic [DW-1:0] din, input bit dready);
        set_inputs(en, valid, din, dready);
        @(negedge i_clk);
        model_step();
        @(posedge i_clk); #1;
    endtask

    task automatic reset_pulse();
        i_rst = 1'b1;
        #1;
        chk("rst_outputs_zero", |{o_din_ready, o_smp_we, ov_smp_waddr, ov_smp_wdata, ov_smp_raddr,
                                  ov_coef_raddr, o_mac_clr, o_mac_en, o_dout_valid}, 0);
        chk("rst_busy", o_busy, (c_clear_cycles > 0));
        @(posedge i_clk); #1;
        chk("rst_dout_valid", o_dout_valid, 0);
        i_rst = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && (m_run || m_clear_left > 0); i++) drive_cycle(1, 0, '0, 1);
        chk("settle_idle_busy", o_busy, 0);
    endtask

    typedef struct {
        bit            valid;
        logic [DW-1:0] din;
        bit            we;
        logic [DW-1:0] wdata;
        int            sr;
        int            cr;
        bit            mac;
        bit            clr;
        bit            dv;
        bit            rdy;
    } vec_t;

    function automatic vec_t mk(bit v, logic [DW-1:0] d, bit we, logic [DW-1:0] wd, int sr, int cr,
                                bit mac, bit clr, bit dv, bit rdy);
        vec_t r;
        r.valid = v; r.din = d; r.we = we; r.wdata = wd; r.sr = sr; r.cr = cr;
        r.mac = mac; r.clr = clr; r.dv = dv; r.rdy = rdy;
        return r;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(1, 24'h000123, 1, 24'h000123, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, '0, 0, '0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, '0, 0, '0, 7, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, '0, 0, '0, 6, 2, 1, 1, 0, 0);
        tbl[4]  = mk(0, '0, 0, '0, 5, 3, 1, 0, 0, 0);
        tbl[5]  = mk(0, '0, 0, '0, 4, 4, 1, 0, 0, 0);
        tbl[6]  = mk(0, '0, 0, '0, 3, 5, 1, 0, 0, 0);
        tbl[7]  = mk(0, '0, 0, '0, 2, 6, 1, 0, 0, 0);
        tbl[8]  = mk(0, '0, 0, '0, 1, 7, 1, 0, 0, 0);
        tbl[9]  = mk(0, '0, 0, '0, 1, 7, 1, 0, 0, 0);
        tbl[10] = mk(0, '0, 0, '0, 1, 7, 1, 0, 0, 0);
        tbl[11] = mk(0, '0, 0, '0, 1, 7, 0, 0, 1, 0);

        g_cyc = 0; g_acc_cyc = 0; g_dv_first = -1;
        model_reset();

        @(posedge i_clk); #1;
        reset_pulse();

        // Post-reset clear pass (only when the feature is built in).
        for (int i = 0; i < c_clear_cycles; i++) drive_cycle(1, 0, '0, 0);

        // Single sample, table of expected per-cycle outputs.
        for (int r = 0; r < 12; r++) begin
            set_inputs(1, tbl[r].valid, tbl[r].din, 0);
            @(negedge i_clk);
            chk("tbl_we",    o_smp_we,      tbl[r].we);
            if (tbl[r].we) chk("tbl_waddr", ov_smp_waddr, 0);
            chk("tbl_wdata", ov_smp_wdata,  tbl[r].wdata);
            chk("tbl_raddr", ov_smp_raddr,  tbl[r].sr);
            chk("tbl_coef",  ov_coef_raddr, tbl[r].cr);
            chk("tbl_mac",   o_mac_en,      tbl[r].mac);
            chk("tbl_clr",   o_mac_clr,     tbl[r].clr);
            chk("tbl_dv",    o_dout_valid,  tbl[r].dv);
            chk("tbl_rdy",   o_din_ready,   tbl[r].rdy);
            model_step();
            @(posedge i_clk); #1;
        end

        // Consumer stalls for 5 cycles, then accepts.
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, '0, 0);
        drive_cycle(1, 0, '0, 1);
        drive_cycle(1, 0, '0, 0);

        // Nine back-to-back samples: write pointer wraps.
        for (int s = 0; s < 9; s++) begin
            drive_cycle(1, 1, DW'($urandom), 1);
            for (int i = 0; i < 40 && m_run; i++) drive_cycle(1, 1, DW'($urandom), 1);
        end
        settle();

        // Enable low for 3 cycles while k=4 is on the address bus.
        g_dv_first = -1;
        for (int c = 0; c < 20; c++) drive_cycle(!(c >= 5 && c <= 7), (c == 0), 24'h00ABCD, 1);
        chk("dv_latency_freeze", g_dv_first - g_acc_cyc, 14);
        settle();

        // Reset while k=5 is on the address bus.
        g_dv_first = -1;
        drive_cycle(1, 1, 24'h0F0F0F, 0);
        for (int c = 1; c < 6; c++) drive_cycle(1, 0, '0, 0);
        chk("pre_rst_raddr_k5", ov_coef_raddr, 5);
        reset_pulse();
        for (int i = 0; i < c_clear_cycles; i++) drive_cycle(1, 0, '0, 0);
        drive_cycle(1, 1, 24'h000777, 1);
        settle();
        chk("no_dv_before_restart", (g_dv_first >= 0 && g_dv_first < g_acc_cyc), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++)
            drive_cycle(($urandom_range(0, 99) < 85), $urandom_range(0, 1), DW'($urandom),
                        $urandom_range(0, 1));
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
